// File: rtl/dport_uart_tx.sv
// Debug-port consumer: merges two byte write ports into a FIFO and serialises
// the bytes as UART 8N1, with sticky overflow and a drained-after-done flag.
module dport_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_AW      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] dport_out1,
  input  logic       dport_write1,
  input  logic [7:0] dport_out2,
  input  logic       dport_write2,
  input  logic       done,
  output logic       tx,
  output logic       busy,
  output logic       overflow,
  output logic       drained
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int BW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0]    BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0] DEPTH_W   = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_reg, rd_ptr_reg, addr2;
  logic [FIFO_AW:0]   count_reg, free;
  logic [1:0]         n_acc;
  logic               accept1, accept2, drop, pop;
  logic               overflow_reg, done_seen_reg, drained_reg;

  state_t             state_reg, state_next;
  logic [BW-1:0]      baud_reg, baud_next;
  logic [2:0]         bit_reg, bit_next;
  logic [7:0]         shift_reg, shift_next;
  logic               tx_reg, tx_next;
  logic               baud_wrap;

  // Room is judged on the pre-edge count, so a same-cycle pop never helps.
  assign free    = DEPTH_W - count_reg;
  assign accept1 = dport_write1 && (free != '0);
  assign accept2 = dport_write2 &&
                   (dport_write1 ? (free >= (FIFO_AW + 1)'(2)) : (free != '0));
  assign drop    = (dport_write1 & ~accept1) | (dport_write2 & ~accept2);
  assign addr2   = wr_ptr_reg + FIFO_AW'(accept1);
  assign n_acc   = {1'b0, accept1} + {1'b0, accept2};

  always_ff @(posedge clk) begin
    if (accept1) mem[wr_ptr_reg] <= dport_out1;
    if (accept2) mem[addr2]      <= dport_out2;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      done_seen_reg <= 1'b0;
      drained_reg   <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_reg + FIFO_AW'(n_acc);
      rd_ptr_reg    <= rd_ptr_reg + FIFO_AW'(pop);
      count_reg     <= count_reg + (FIFO_AW + 1)'(n_acc) - (FIFO_AW + 1)'(pop);
      overflow_reg  <= overflow_reg | drop;
      done_seen_reg <= done_seen_reg | done;
      drained_reg   <= done_seen_reg & ~busy;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      baud_reg  <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      tx_reg    <= 1'b1;
    end else begin
      state_reg <= state_next;
      baud_reg  <= baud_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      tx_reg    <= tx_next;
    end
  end

  assign baud_wrap = (baud_reg == BAUD_LAST);

  // The shift register doubles as the registered read port of the FIFO.
  always_comb begin
    state_next = state_reg;
    baud_next  = baud_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    tx_next    = tx_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        tx_next   = 1'b1;
        baud_next = '0;
        bit_next  = '0;
        if (count_reg != '0) begin
          pop        = 1'b1;
          shift_next = mem[rd_ptr_reg];
          state_next = START;
          tx_next    = 1'b0;
        end
      end
      START: begin
        if (baud_wrap) begin
          baud_next  = '0;
          state_next = DATA;
          tx_next    = shift_reg[0];
        end else begin
          baud_next = baud_reg + BW'(1);
        end
      end
      DATA: begin
        if (baud_wrap) begin
          baud_next = '0;
          if (bit_reg == 3'd7) begin
            bit_next   = '0;
            state_next = STOP;
            tx_next    = 1'b1;
          end else begin
            bit_next   = bit_reg + 3'd1;
            shift_next = {1'b0, shift_reg[7:1]};
            tx_next    = shift_reg[1];
          end
        end else begin
          baud_next = baud_reg + BW'(1);
        end
      end
      STOP: begin
        if (baud_wrap) begin
          baud_next = '0;
          // Chain straight into the next frame when more data is waiting.
          if (count_reg != '0) begin
            pop        = 1'b1;
            shift_next = mem[rd_ptr_reg];
            state_next = START;
            tx_next    = 1'b0;
          end else begin
            state_next = IDLE;
            tx_next    = 1'b1;
          end
        end else begin
          baud_next = baud_reg + BW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

  assign tx       = tx_reg;
  assign busy     = (state_reg != IDLE) | (count_reg != '0);
  assign overflow = overflow_reg;
  assign drained  = drained_reg;

endmodule

// File: tb/tb_dport_uart_tx.sv
// Bench for dport_uart_tx: directed scenarios plus random traffic, checked each
// cycle against a queue-based model of FIFO occupancy and 10-bit-cell frames.
module tb_dport_uart_tx;

  localparam int N     = 4;
  localparam int DEPTH = 16;
  localparam int FRAME = 10 * N;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] dport_out1, dport_out2;
  logic       dport_write1, dport_write2, done;
  logic       tx, busy, overflow, drained;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [7:0] mq [$];
  logic [7:0] cur;
  int         fpos;
  logic       ovf_m, ds_m, drn_m;

  dport_uart_tx #(.CLKS_PER_BIT(N), .FIFO_AW(4)) dut (
    .clk(clk), .rst(rst),
    .dport_out1(dport_out1), .dport_write1(dport_write1),
    .dport_out2(dport_out2), .dport_write2(dport_write2),
    .done(done), .tx(tx), .busy(busy), .overflow(overflow), .drained(drained)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic exp_tx();
    int c;
    if (fpos < 0) return 1'b1;
    c = fpos / N;
    if (c == 0) return 1'b0;
    if (c == 9) return 1'b1;
    return cur[c-1];
  endfunction

  function automatic logic exp_busy();
    return (fpos >= 0) || (mq.size() != 0);
  endfunction

  task automatic model_reset();
    mq.delete();
    fpos  = -1;
    cur   = '0;
    ovf_m = 1'b0;
    ds_m  = 1'b0;
    drn_m = 1'b0;
  endtask

  // One clock edge of the model: frames last FRAME cycles, back to back.
  task automatic model_edge(input logic w1, input logic [7:0] d1,
                            input logic w2, input logic [7:0] d2, input logic dn);
    int   pre, fr;
    logic a1, a2, busy_pre;
    pre      = mq.size();
    fr       = DEPTH - pre;
    busy_pre = exp_busy();
    a1 = w1 && (fr >= 1);
    a2 = w2 && (fr >= (w1 ? 2 : 1));
    if ((w1 && !a1) || (w2 && !a2)) ovf_m = 1'b1;
    if ((fpos < 0 || fpos == FRAME - 1) && pre > 0) begin
      cur  = mq.pop_front();
      fpos = 0;
    end else if (fpos == FRAME - 1) begin
      fpos = -1;
    end else if (fpos >= 0) begin
      fpos++;
    end
    if (a1) mq.push_back(d1);
    if (a2) mq.push_back(d2);
    drn_m = ds_m && !busy_pre;
    if (dn) ds_m = 1'b1;
  endtask

  task automatic tick(input logic w1, input logic [7:0] d1,
                      input logic w2, input logic [7:0] d2, input logic dn);
    dport_write1 = w1; dport_out1 = d1;
    dport_write2 = w2; dport_out2 = d2;
    done = dn;
    @(posedge clk);
    model_edge(w1, d1, w2, d2, dn);
    #1;
    chk("tx", tx, exp_tx());
    chk("busy", busy, exp_busy());
    chk("overflow", overflow, ovf_m);
    chk("drained", drained, drn_m);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 2000 && !(fpos < 0 && mq.size() == 0); i++) idle(1);
    idle(1);
    chk("drain_busy", busy, 1'b0);
  endtask

  task automatic do_reset();
    dport_write1 = 1'b0; dport_write2 = 1'b0; done = 1'b0;
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_drained", drained, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
  endtask

  initial begin
    logic [9:0] pat;
    int         lows;
    rst = 1'b1;
    dport_out1 = '0; dport_out2 = '0;
    dport_write1 = 1'b0; dport_write2 = 1'b0; done = 1'b0;
    model_reset();
    do_reset();
    idle(3);

    // 1: single 0x41, exact bit cells
    pat = 10'b1010000010;
    tick(1'b1, 8'h41, 1'b0, 8'h00, 1'b0);
    chk("s1_still_idle", tx, 1'b1);
    for (int i = 0; i < FRAME; i++) begin
      idle(1);
      chk("s1_cell", tx, pat[i / N]);
    end
    idle(1);
    chk("s1_busy_end", busy, 1'b0);

    // 2: dual write, back-to-back frames
    tick(1'b1, 8'h11, 1'b1, 8'h22, 1'b0);
    drain();
    chk("s2_overflow", overflow, 1'b0);

    // 3: 17 writes while busy, last one dropped
    tick(1'b1, 8'hC3, 1'b0, 8'h00, 1'b0);
    idle(1);
    for (int i = 0; i < 17; i++) begin
      tick(1'b1, 8'(i), 1'b0, 8'h00, 1'b0);
      if (i == 15) chk("s3_ovf_after16", overflow, 1'b0);
    end
    chk("s3_ovf_after17", overflow, 1'b1);
    drain();

    // 4: one slot free, dual write keeps port 1 only
    do_reset();
    tick(1'b1, 8'hC4, 1'b0, 8'h00, 1'b0);
    idle(1);
    for (int i = 0; i < 15; i++) tick(1'b1, 8'(8'h60 + i), 1'b0, 8'h00, 1'b0);
    chk("s4_ovf_before", overflow, 1'b0);
    tick(1'b1, 8'hAA, 1'b1, 8'h55, 1'b0);
    chk("s4_ovf_after", overflow, 1'b1);
    chk("s4_last_queued", mq[mq.size()-1], 8'hAA);
    drain();

    // 5: done with 3 bytes pending
    do_reset();
    tick(1'b1, 8'h31, 1'b1, 8'h32, 1'b0);
    tick(1'b1, 8'h33, 1'b0, 8'h00, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 400 && busy; i++) begin
      chk("s5_drained_while_busy", drained, 1'b0);
      idle(1);
    end
    chk("s5_timeout", busy, 1'b0);
    chk("s5_drained_lag", drained, 1'b0);
    idle(1);
    chk("s5_drained_set", drained, 1'b1);
    tick(1'b1, 8'h34, 1'b0, 8'h00, 1'b0);
    idle(1);
    chk("s5_drained_drop", drained, 1'b0);
    drain();

    // 6: reset mid-DATA of 0xF0
    tick(1'b1, 8'hF0, 1'b0, 8'h00, 1'b0);
    idle(1 + N + 2 * N);
    chk("s6_in_frame", busy, 1'b1);
    do_reset();
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      idle(1);
      if (tx === 1'b0) lows++;
    end
    chk("s6_quiet", lows, 0);

    // Random traffic: sparse phase, then a dense phase that overflows
    for (int i = 0; i < 800; i++)
      tick($urandom_range(0, 99) < 4, 8'($urandom), $urandom_range(0, 99) < 3,
           8'($urandom), $urandom_range(0, 199) == 0);
    for (int i = 0; i < 300; i++)
      tick($urandom_range(0, 99) < 40, 8'($urandom), $urandom_range(0, 99) < 40,
           8'($urandom), 1'b0);
    drain();
    idle(2);
    chk("rand_ovf", overflow, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
